// File: rtl/runtime_checker.sv
// runtime_checker
//   Run-time self-check engine for a RISC-V core. Holds a table of expected
//   results (runtime entries keyed by instruction address, plus final-state
//   entries). When a matching address commits, the core is halted and each
//   target is read through the probe port and compared. Pass/fail counts and
//   first-failure details are kept until reset.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   cfg_*                  expectation entry load (valid/ready, IDLE only)
//   start                  IDLE -> RUN pulse
//   commit_valid/pc        retired-instruction stream from the core
//   finish                 program-end pulse
//   halt                   core must not commit while high
//   probe_*                target read request / PROBE_LAT-delayed response
//   pass_count/fail_count  saturating result counters
//   fail_*                 sticky first-failure record
//   proto_err              sticky protocol violation
//   done                   high once the final pass has completed
module runtime_checker #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 6,
    parameter int DEPTH     = 64,
    parameter int PROBE_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_kind,
    input  logic              cfg_final,
    input  logic [IDX_W-1:0]  cfg_index,
    input  logic [XLEN-1:0]   cfg_value,
    input  logic              start,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_pc,
    input  logic              finish,
    output logic              halt,
    output logic              probe_valid,
    output logic [1:0]        probe_kind,
    output logic [IDX_W-1:0]  probe_index,
    input  logic [XLEN-1:0]   probe_data,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [1:0]        fail_kind,
    output logic [IDX_W-1:0]  fail_index,
    output logic [XLEN-1:0]   fail_got,
    output logic [XLEN-1:0]   fail_exp,
    output logic              proto_err,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int unsigned SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TCNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0]  LAT    = 3'(PROBE_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Expectation table; occupancy is tracked by count_q (entries 0..count_q-1)
    logic [ADDR_W-1:0] tbl_addr  [DEPTH];
    logic [1:0]        tbl_kind  [DEPTH];
    logic [IDX_W-1:0]  tbl_index [DEPTH];
    logic [XLEN-1:0]   tbl_value [DEPTH];
    logic [DEPTH-1:0]  tbl_final;

    state_t            state_q;
    logic [TCNT_W-1:0] count_q;
    logic [DEPTH-1:0]  pend_q;
    logic [SEL_W-1:0]  sel_q;
    logic [2:0]        wait_q;
    logic              finish_pend_q;

    logic              cfg_accept;
    logic [SEL_W-1:0]  wr_slot;
    logic [DEPTH-1:0]  match_vec;
    logic [DEPTH-1:0]  final_vec;
    logic [DEPTH-1:0]  sel_onehot;
    logic [DEPTH-1:0]  rem_vec;
    logic [SEL_W-1:0]  match_sel;
    logic [SEL_W-1:0]  final_sel;
    logic [SEL_W-1:0]  rem_sel;
    logic              hit;

    function automatic logic [SEL_W-1:0] first_set(input logic [DEPTH-1:0] v);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (v[i] && !found) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign cfg_ready  = (state_q == S_IDLE) && (count_q < TCNT_W'(DEPTH));
    assign cfg_accept = cfg_valid && cfg_ready;
    assign wr_slot    = SEL_W'(count_q);
    assign halt       = (state_q == S_CHECK) || (state_q == S_FINAL);
    assign done       = (state_q == S_DONE);
    assign hit        = (probe_data == tbl_value[sel_q]);

    always_comb begin
        match_vec  = '0;
        final_vec  = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (TCNT_W'(i) < count_q) begin
                if (tbl_final[i]) begin
                    final_vec[i] = 1'b1;
                end else if (tbl_addr[i] == commit_pc) begin
                    match_vec[i] = 1'b1;
                end
            end
        end
        sel_onehot[sel_q] = 1'b1;
        rem_vec   = pend_q & ~sel_onehot;
        match_sel = first_set(match_vec);
        final_sel = first_set(final_vec);
        rem_sel   = first_set(rem_vec);
    end

    // Table payload needs no reset: occupancy lives in count_q
    always_ff @(posedge clock) begin
        if (cfg_accept && (cfg_kind != 2'b11)) begin
            tbl_addr[wr_slot]  <= cfg_addr;
            tbl_kind[wr_slot]  <= cfg_kind;
            tbl_index[wr_slot] <= cfg_index;
            tbl_value[wr_slot] <= cfg_value;
            tbl_final[wr_slot] <= cfg_final;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            pend_q        <= '0;
            sel_q         <= '0;
            wait_q        <= '0;
            finish_pend_q <= 1'b0;
            probe_valid   <= 1'b0;
            probe_kind    <= '0;
            probe_index   <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            fail_valid    <= 1'b0;
            fail_addr     <= '0;
            fail_kind     <= '0;
            fail_index    <= '0;
            fail_got      <= '0;
            fail_exp      <= '0;
            proto_err     <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_accept) begin
                        if (cfg_kind == 2'b11) begin
                            proto_err <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    // A matching commit wins over a same-cycle finish; the
                    // finish is remembered and the final pass follows
                    if (commit_valid && (|match_vec)) begin
                        state_q       <= S_CHECK;
                        pend_q        <= match_vec;
                        finish_pend_q <= finish;
                        sel_q         <= match_sel;
                        wait_q        <= '0;
                        probe_valid   <= 1'b1;
                        probe_kind    <= tbl_kind[match_sel];
                        probe_index   <= tbl_index[match_sel];
                    end else if (finish) begin
                        state_q <= S_FINAL;
                        pend_q  <= final_vec;
                        sel_q   <= final_sel;
                        wait_q  <= '0;
                        if (|final_vec) begin
                            probe_valid <= 1'b1;
                            probe_kind  <= tbl_kind[final_sel];
                            probe_index <= tbl_index[final_sel];
                        end
                    end
                end

                S_CHECK, S_FINAL: begin
                    if (commit_valid) begin
                        proto_err <= 1'b1;
                    end
                    if ((state_q == S_CHECK) && finish) begin
                        finish_pend_q <= 1'b1;
                    end
                    if (pend_q == '0) begin
                        // Only reachable as a FINAL pass with no final entries
                        state_q <= S_DONE;
                    end else if (wait_q != LAT) begin
                        wait_q <= wait_q + 1'b1;
                    end else begin
                        if (hit) begin
                            if (pass_count != CNT_MAX) begin
                                pass_count <= pass_count + 1'b1;
                            end
                        end else begin
                            if (fail_count != CNT_MAX) begin
                                fail_count <= fail_count + 1'b1;
                            end
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_addr  <= tbl_final[sel_q] ? '0 : tbl_addr[sel_q];
                                fail_kind  <= tbl_kind[sel_q];
                                fail_index <= tbl_index[sel_q];
                                fail_got   <= probe_data;
                                fail_exp   <= tbl_value[sel_q];
                            end
                        end
                        pend_q <= rem_vec;
                        wait_q <= '0;
                        if (|rem_vec) begin
                            sel_q       <= rem_sel;
                            probe_valid <= 1'b1;
                            probe_kind  <= tbl_kind[rem_sel];
                            probe_index <= tbl_index[rem_sel];
                        end else if (state_q == S_FINAL) begin
                            state_q <= S_DONE;
                        end else if (finish_pend_q || finish) begin
                            state_q       <= S_FINAL;
                            finish_pend_q <= 1'b0;
                            pend_q        <= final_vec;
                            sel_q         <= final_sel;
                            if (|final_vec) begin
                                probe_valid <= 1'b1;
                                probe_kind  <= tbl_kind[final_sel];
                                probe_index <= tbl_index[final_sel];
                            end
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_DONE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_runtime_checker.sv
// tb_runtime_checker
//   Two instances share all stimulus: dut_a with PROBE_LAT=1 and dut_b with
//   PROBE_LAT=3, both DEPTH=4 and CNT_W=3 so that table-full and counter
//   saturation are reachable. A small target model answers probes for each.
module tb_runtime_checker;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 6;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [1:0]        cfg_kind = '0;
    logic              cfg_final = 1'b0;
    logic [IDX_W-1:0]  cfg_index = '0;
    logic [XLEN-1:0]   cfg_value = '0;
    logic              start = 1'b0;
    logic              commit_valid = 1'b0;
    logic [ADDR_W-1:0] commit_pc = '0;
    logic              finish = 1'b0;

    logic              a_cfg_ready, a_halt, a_probe_valid, a_fail_valid, a_proto, a_done;
    logic [1:0]        a_probe_kind, a_fail_kind;
    logic [IDX_W-1:0]  a_probe_index, a_fail_index;
    logic [XLEN-1:0]   a_probe_data = '0;
    logic [XLEN-1:0]   a_fail_got, a_fail_exp;
    logic [ADDR_W-1:0] a_fail_addr;
    logic [CNT_W-1:0]  a_pass, a_fail;

    logic              b_cfg_ready, b_halt, b_probe_valid, b_fail_valid, b_proto, b_done;
    logic [1:0]        b_probe_kind, b_fail_kind;
    logic [IDX_W-1:0]  b_probe_index, b_fail_index;
    logic [XLEN-1:0]   b_probe_data = '0;
    logic [XLEN-1:0]   b_d1 = '0;
    logic [XLEN-1:0]   b_d2 = '0;
    logic [XLEN-1:0]   b_fail_got, b_fail_exp;
    logic [ADDR_W-1:0] b_fail_addr;
    logic [CNT_W-1:0]  b_pass, b_fail;

    always #5 clock = ~clock;

    runtime_checker #(.XLEN(XLEN), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .DEPTH(DEPTH),
                      .PROBE_LAT(1), .CNT_W(CNT_W)) dut_a (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready), .cfg_addr(cfg_addr),
        .cfg_kind(cfg_kind), .cfg_final(cfg_final), .cfg_index(cfg_index),
        .cfg_value(cfg_value), .start(start), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .finish(finish), .halt(a_halt),
        .probe_valid(a_probe_valid), .probe_kind(a_probe_kind),
        .probe_index(a_probe_index), .probe_data(a_probe_data),
        .pass_count(a_pass), .fail_count(a_fail), .fail_valid(a_fail_valid),
        .fail_addr(a_fail_addr), .fail_kind(a_fail_kind), .fail_index(a_fail_index),
        .fail_got(a_fail_got), .fail_exp(a_fail_exp), .proto_err(a_proto), .done(a_done)
    );

    runtime_checker #(.XLEN(XLEN), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .DEPTH(DEPTH),
                      .PROBE_LAT(3), .CNT_W(CNT_W)) dut_b (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready), .cfg_addr(cfg_addr),
        .cfg_kind(cfg_kind), .cfg_final(cfg_final), .cfg_index(cfg_index),
        .cfg_value(cfg_value), .start(start), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .finish(finish), .halt(b_halt),
        .probe_valid(b_probe_valid), .probe_kind(b_probe_kind),
        .probe_index(b_probe_index), .probe_data(b_probe_data),
        .pass_count(b_pass), .fail_count(b_fail), .fail_valid(b_fail_valid),
        .fail_addr(b_fail_addr), .fail_kind(b_fail_kind), .fail_index(b_fail_index),
        .fail_got(b_fail_got), .fail_exp(b_fail_exp), .proto_err(b_proto), .done(b_done)
    );

    // Target model: register file, pc, data memory
    logic [XLEN-1:0] regs [64];
    logic [XLEN-1:0] mem  [64];
    logic [XLEN-1:0] pc_val = '0;

    function automatic logic [XLEN-1:0] lookup(input logic [1:0] k, input logic [IDX_W-1:0] i);
        case (k)
            2'b00:   return regs[i];
            2'b01:   return pc_val;
            2'b10:   return mem[i];
            default: return 32'h0BAD_BAD0;
        endcase
    endfunction

    always @(posedge clock) begin
        a_probe_data <= a_probe_valid ? lookup(a_probe_kind, a_probe_index) : '0;
    end

    always @(posedge clock) begin
        b_d1         <= b_probe_valid ? lookup(b_probe_kind, b_probe_index) : '0;
        b_d2         <= b_d1;
        b_probe_data <= b_d2;
    end

    int errors = 0;
    int checks = 0;
    int np;
    logic [1:0]       pk   [8];
    logic [IDX_W-1:0] pidx [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic cfg_put(input logic [31:0] addr, input logic [1:0] kind, input logic fin,
                           input logic [IDX_W-1:0] idx, input logic [31:0] val);
        logic ok;
        cfg_addr = addr; cfg_kind = kind; cfg_final = fin; cfg_index = idx; cfg_value = val;
        cfg_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (a_cfg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        cfg_valid = 1'b0;
        chk("cfg_accept", ok, 1);
    endtask

    // Drives one commit/finish cycle, then counts halt cycles of both
    // instances and records dut_a's probes until both have released halt.
    task automatic commit(input logic [31:0] pc, input logic cv, input logic fin,
                          output int ha, output int hb);
        logic settled;
        commit_valid = cv; commit_pc = pc; finish = fin;
        @(posedge clock); #1;
        commit_valid = 1'b0; finish = 1'b0;
        ha = 0; hb = 0; np = 0; settled = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (a_probe_valid && np < 8) begin
                pk[np] = a_probe_kind;
                pidx[np] = a_probe_index;
                np++;
            end
            if (a_halt) ha++;
            if (b_halt) hb++;
            if (!a_halt && !b_halt) begin
                settled = 1'b1;
                break;
            end
        end
        chk("halt_release", settled, 1);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        int          halt_a;
        int          halt_b;
        int          pass_e;
        int          fail_e;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ha, hb;
        logic settled;

        // Table at 0x8:{reg5=42}, 0x4:{reg6=11, pc=0x100}, 0xC:{mem3=0x1235}
        // Model mem3 holds 0x1234, so 0xC fails. CNT_W=3 saturates at 7.
        vecs[0] = '{32'h08, 2, 4, 1, 0};
        vecs[1] = '{32'h20, 0, 0, 1, 0};
        vecs[2] = '{32'h04, 4, 8, 3, 0};
        vecs[3] = '{32'h04, 4, 8, 5, 0};
        vecs[4] = '{32'h0C, 2, 4, 5, 1};
        vecs[5] = '{32'h08, 2, 4, 6, 1};
        vecs[6] = '{32'h04, 4, 8, 7, 1};
        vecs[7] = '{32'h08, 2, 4, 7, 1};

        for (int i = 0; i < 64; i++) begin
            regs[i] = '0;
            mem[i]  = '0;
        end
        regs[5] = 32'd42;
        regs[6] = 32'd11;
        pc_val  = 32'h100;
        mem[3]  = 32'h1234;

        // Reset state, observed while reset is held low
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_cfg_ready", a_cfg_ready, 1);
        chk("rst_halt", a_halt, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_fail", a_fail, 0);
        chk("rst_fail_valid", a_fail_valid, 0);
        chk("rst_proto", a_proto, 0);
        chk("rst_probe_valid", a_probe_valid, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Group 1: table-driven commits
        cfg_put(32'h08, 2'b00, 1'b0, 6'd5, 32'd42);
        cfg_put(32'h04, 2'b00, 1'b0, 6'd6, 32'd11);
        cfg_put(32'h04, 2'b01, 1'b0, 6'd0, 32'h100);
        cfg_put(32'h0C, 2'b10, 1'b0, 6'd3, 32'h1235);
        do_start();
        for (int v = 0; v < 8; v++) begin
            commit(vecs[v].pc, 1'b1, 1'b0, ha, hb);
            chk($sformatf("v%0d_halt_a", v), ha, vecs[v].halt_a);
            chk($sformatf("v%0d_halt_b", v), hb, vecs[v].halt_b);
            chk($sformatf("v%0d_pass_a", v), a_pass, vecs[v].pass_e);
            chk($sformatf("v%0d_fail_a", v), a_fail, vecs[v].fail_e);
            chk($sformatf("v%0d_pass_b", v), b_pass, vecs[v].pass_e);
            chk($sformatf("v%0d_fail_b", v), b_fail, vecs[v].fail_e);
        end
        chk("g1_fail_valid", a_fail_valid, 1);
        chk("g1_fail_addr", a_fail_addr, 32'h0C);
        chk("g1_fail_kind", a_fail_kind, 2);
        chk("g1_fail_index", a_fail_index, 3);
        chk("g1_fail_got", a_fail_got, 32'h1234);
        chk("g1_fail_exp", a_fail_exp, 32'h1235);
        chk("g1_proto", a_proto, 0);
        // Second failure must not overwrite the first-failure record
        regs[5] = 32'd43;
        commit(32'h08, 1'b1, 1'b0, ha, hb);
        chk("g1_sticky_fail_cnt", a_fail, 2);
        chk("g1_sticky_index", a_fail_index, 3);
        chk("g1_sticky_got", a_fail_got, 32'h1234);
        chk("g1_sticky_addr", a_fail_addr, 32'h0C);

        // Group 2: three checks at one address, served lowest index first
        do_reset();
        regs[1] = 32'd7;
        regs[2] = 32'd5;
        mem[33] = 32'hDEAD;
        cfg_put(32'h10, 2'b00, 1'b0, 6'd1, 32'd7);
        cfg_put(32'h10, 2'b00, 1'b0, 6'd2, 32'd9);
        cfg_put(32'h10, 2'b10, 1'b0, 6'd33, 32'hDEAD);
        do_start();
        commit(32'h10, 1'b1, 1'b0, ha, hb);
        chk("g2_halt_a", ha, 6);
        chk("g2_halt_b", hb, 12);
        chk("g2_nprobes", np, 3);
        chk("g2_probe0_idx", pidx[0], 1);
        chk("g2_probe1_idx", pidx[1], 2);
        chk("g2_probe2_idx", pidx[2], 33);
        chk("g2_probe2_kind", pk[2], 2);
        chk("g2_pass", a_pass, 2);
        chk("g2_fail", a_fail, 1);
        chk("g2_fail_index", a_fail_index, 2);
        chk("g2_fail_got", a_fail_got, 5);
        chk("g2_fail_exp", a_fail_exp, 9);
        chk("g2_fail_addr", a_fail_addr, 32'h10);
        chk("g2_fail_kind", a_fail_kind, 0);
        chk("g2_b_fail_valid", b_fail_valid, 1);
        chk("g2_b_fail_addr", b_fail_addr, 32'h10);
        chk("g2_b_fail_kind", b_fail_kind, 0);
        chk("g2_b_fail_index", b_fail_index, 2);
        chk("g2_b_fail_got", b_fail_got, 5);
        chk("g2_b_fail_exp", b_fail_exp, 9);

        // Group 3: reserved kind discarded, table full, held offer, start
        do_reset();
        cfg_put(32'h70, 2'b11, 1'b0, 6'd0, 32'd0);
        chk("g3_proto_kind11", a_proto, 1);
        cfg_put(32'h50, 2'b00, 1'b0, 6'd1, 32'd7);
        cfg_put(32'h54, 2'b00, 1'b0, 6'd1, 32'd7);
        cfg_put(32'h58, 2'b00, 1'b0, 6'd1, 32'd7);
        cfg_put(32'h5C, 2'b00, 1'b0, 6'd1, 32'd7);
        cfg_addr = 32'h60; cfg_kind = 2'b00; cfg_final = 1'b0; cfg_index = 6'd1; cfg_value = 32'd7;
        cfg_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("g3_full_ready", a_cfg_ready, 0);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        chk("g3_run_ready", a_cfg_ready, 0);
        commit(32'h60, 1'b1, 1'b0, ha, hb);
        chk("g3_fifth_halt", ha, 0);
        chk("g3_fifth_pass", a_pass, 0);
        commit(32'h5C, 1'b1, 1'b0, ha, hb);
        chk("g3_fourth_halt", ha, 2);
        chk("g3_fourth_pass", a_pass, 1);

        // Group 4: finish with a matching commit; runtime check then final pass
        do_reset();
        pc_val   = 32'h40;
        regs[10] = 32'd0;
        regs[3]  = 32'h33;
        cfg_put(32'h20, 2'b01, 1'b1, 6'd0, 32'h40);
        cfg_put(32'h00, 2'b00, 1'b1, 6'd10, 32'd0);
        cfg_put(32'h20, 2'b00, 1'b0, 6'd3, 32'h33);
        do_start();
        commit(32'h20, 1'b1, 1'b1, ha, hb);
        chk("g4_halt_a", ha, 6);
        chk("g4_halt_b", hb, 12);
        chk("g4_nprobes", np, 3);
        chk("g4_probe0", {pk[0], pidx[0]}, {2'd0, 6'd3});
        chk("g4_probe1", {pk[1], pidx[1]}, {2'd1, 6'd0});
        chk("g4_probe2", {pk[2], pidx[2]}, {2'd0, 6'd10});
        chk("g4_done_a", a_done, 1);
        chk("g4_done_b", b_done, 1);
        chk("g4_pass", a_pass, 3);
        chk("g4_fail", a_fail, 0);

        // Group 5: commit during halt, loop re-check, empty final pass
        do_reset();
        cfg_put(32'h04, 2'b00, 1'b0, 6'd6, 32'd11);
        do_start();
        commit_valid = 1'b1; commit_pc = 32'h04;
        @(posedge clock); #1;
        @(posedge clock); #1;
        commit_valid = 1'b0;
        settled = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (!a_halt && !b_halt) begin
                settled = 1'b1;
                break;
            end
        end
        chk("g5_settle", settled, 1);
        @(posedge clock); #1;
        chk("g5_proto_a", a_proto, 1);
        chk("g5_proto_b", b_proto, 1);
        chk("g5_pass_after_halt_commit", a_pass, 1);
        chk("g5_pass_b", b_pass, 1);
        commit(32'h04, 1'b1, 1'b0, ha, hb);
        chk("g5_loop_pass", a_pass, 2);
        commit(32'h00, 1'b0, 1'b1, ha, hb);
        chk("g5_final_empty_halt_a", ha, 1);
        chk("g5_final_empty_halt_b", hb, 1);
        chk("g5_done", a_done, 1);

        // Group 6: asynchronous reset in the middle of a PROBE_LAT=3 check
        do_reset();
        regs[5] = 32'd42;
        cfg_put(32'h08, 2'b00, 1'b0, 6'd5, 32'd42);
        do_start();
        commit(32'h08, 1'b1, 1'b0, ha, hb);
        chk("g6_pre_halt_b", hb, 4);
        chk("g6_pre_pass_b", b_pass, 1);
        commit_valid = 1'b1; commit_pc = 32'h08;
        @(posedge clock); #1;
        commit_valid = 1'b0;
        @(negedge clock);
        chk("g6_in_check", b_halt, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("g6_rst_halt", b_halt, 0);
        chk("g6_rst_pass", b_pass, 0);
        chk("g6_rst_fail", b_fail, 0);
        chk("g6_rst_idle", b_cfg_ready, 1);
        chk("g6_rst_probe", b_probe_valid, 0);
        chk("g6_rst_done", b_done, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
